// File: rtl/mem_wb_pipe_pkg.sv
// Shared widths, nop payload values and control constants for the MEM->WB boundary.
package mem_wb_pipe_pkg;

  localparam int RegAw = 5;
  localparam int RegDw = 32;
  localparam int CsrAw = 12;
  localparam int CsrDw = 32;
  localparam int CntW  = 64;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegAw-1:0] RegAddrNop = '0;
  localparam logic [RegDw-1:0] RegNop     = '0;
  localparam logic [CsrAw-1:0] CsrAddrNop = '0;
  localparam logic [CsrDw-1:0] CsrNop     = '0;

endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// Valid/ready payload register with flush; MEM_WB_SKID_EN selects the
// two-entry skid form, otherwise a single slot.
module pipe_skid_buf
  import mem_wb_pipe_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic [PW-1:0] main_q, main_d;
  logic          main_vld_q, main_vld_d;
  logic          in_xfer, out_xfer;

  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign out_xfer  = main_vld_q && out_ready;

`ifdef MEM_WB_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  logic          skid_vld_q, skid_vld_d;

  // ready comes straight from a flop: no out_ready->in_ready path
  assign in_ready = !skid_vld_q;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_xfer && skid_vld_q) begin
      main_d     = skid_q;
      skid_vld_d = 1'b0;
    end else if (out_xfer) begin
      main_vld_d = in_xfer;
      if (in_xfer) main_d = in_data;
    end else if (in_xfer && main_vld_q) begin
      skid_d     = in_data;
      skid_vld_d = 1'b1;
    end else if (in_xfer) begin
      main_d     = in_data;
      main_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready = !main_vld_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
    end else if (in_xfer) begin
      main_d     = in_data;
      main_vld_d = 1'b1;
    end else if (out_xfer) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
    end
  end
`endif

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB boundary: GPR/CSR write triples under valid/ready with flush and
// a retire counter. Define MEM_WB_SKID_EN for the two-entry skid buffer.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int REG_AW = RegAw,
  parameter int REG_DW = RegDw,
  parameter int CSR_AW = CsrAw,
  parameter int CSR_DW = CsrDw,
  parameter int CNT_W  = CntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_waddr,
  input  logic [REG_DW-1:0] in_wdata,
  input  logic              in_we,
  input  logic              in_csr_we,
  input  logic [CSR_AW-1:0] in_csr_waddr,
  input  logic [CSR_DW-1:0] in_csr_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_waddr,
  output logic [REG_DW-1:0] out_wdata,
  output logic              out_we,
  output logic              out_csr_we,
  output logic [CSR_AW-1:0] out_csr_waddr,
  output logic [CSR_DW-1:0] out_csr_wdata,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int PW = 2 + REG_AW + REG_DW + CSR_AW + CSR_DW;

  logic [PW-1:0]     in_data, out_data;
  logic              h_we, h_csr_we;
  logic [REG_AW-1:0] h_waddr;
  logic [REG_DW-1:0] h_wdata;
  logic [CSR_AW-1:0] h_csr_waddr;
  logic [CSR_DW-1:0] h_csr_wdata;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign in_data = {in_we, in_waddr, in_wdata,
                    in_csr_we, in_csr_waddr, in_csr_wdata};

  pipe_skid_buf #(.PW(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign {h_we, h_waddr, h_wdata,
          h_csr_we, h_csr_waddr, h_csr_wdata} = out_data;

  // an empty stage presents a nop so the write ports never see stale data
  assign out_we        = out_valid ? h_we        : WriteDisable;
  assign out_csr_we    = out_valid ? h_csr_we    : WriteDisable;
  assign out_waddr     = out_valid ? h_waddr     : REG_AW'(RegAddrNop);
  assign out_wdata     = out_valid ? h_wdata     : REG_DW'(RegNop);
  assign out_csr_waddr = out_valid ? h_csr_waddr : CSR_AW'(CsrAddrNop);
  assign out_csr_wdata = out_valid ? h_csr_wdata : CSR_DW'(CsrNop);

  // an output transfer retires even when flush lands in the same cycle
  assign cnt_en = (out_valid && out_ready) ? WriteEnable : WriteDisable;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_en == WriteEnable) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;

endmodule
